mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  request pulse; sampled only in IDLE.
REQ-005 OP  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 OPERAND_A  input  32  rs value, driven from register-file READ_1.
REQ-007 OPERAND_B  input  32  rt value, driven from register-file READ_2.
REQ-008 BUSY  output  1  high whenever state is not IDLE.
REQ-009 DONE  output  1  single-cycle pulse: HI/LO just updated.
REQ-010 HI  output  32  product high word / remainder.
REQ-011 LO  output  32  product low word / quotient.
REQ-012 DIV_BY_ZERO  output  1  registered with DONE; high for DIV/DIVU with OPERAND_B = 0, held until next DONE.

Function
REQ-013 States SHALL be IDLE, CALC, FINISH; IDLE->CALC on START; CALC->FINISH after 32nd iteration; FINISH->IDLE unconditionally.
REQ-014 On accepting START (edge N), OP, |OPERAND_A|, |OPERAND_B| and result-sign flags SHALL be latched; later operand changes have no effect.
REQ-015 Edges N+1..N+32 SHALL each perform one iteration (shift-add multiply or restoring divide on magnitudes, 6-bit iteration counter 0..31).
REQ-016 At edge N+33 HI, LO, DIV_BY_ZERO SHALL update and DONE SHALL be high for exactly the following cycle; total latency 33 cycles, fixed for all OP and operand values.
REQ-017 MULT/MULTU: {HI,LO} SHALL equal the full 64-bit signed/unsigned product; signed result negated in FINISH when operand signs differ.
REQ-018 DIV/DIVU: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0, DIV_BY_ZERO=0.
REQ-020 Divide by zero (either signedness) SHALL give LO=0xFFFFFFFF, HI=OPERAND_A as latched, same 33-cycle latency.
REQ-021 START while BUSY SHALL be ignored, no queuing; START in the cycle DONE is high SHALL be accepted (state is IDLE).
REQ-022 HI/LO SHALL hold their last values between operations and change only at FINISH->IDLE or reset.
REQ-023 Consumer (writeback mux into register-file WRITE_DATA) SHALL read HI/LO only when BUSY=0; unit makes no guarantee on intermediate values.

Reset
REQ-024 RST_N low at a rising edge SHALL force IDLE, BUSY=0, DONE=0, DIV_BY_ZERO=0, HI=0, LO=0, counter=0.
REQ-025 Reset mid-operation SHALL abort without any DONE pulse; START sampled in the first cycle with RST_N high SHALL be accepted.

Structure
REQ-026 Shared package SHALL hold OP encodings (MULT, MULTU, DIV, DIVU), the state enum, and constant ITERATIONS=32.
REQ-027 Single module; multiply and divide SHALL share one 64-bit accumulator/shift register; no sub-module.

Verification
REQ-028 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, DONE exactly 33 cycles after START edge, BUSY high 33 cycles.
REQ-029 MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 DIVU 100 / 7 -> LO=0x0000000E, HI=0x00000002, DIV_BY_ZERO=0; DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, DIV_BY_ZERO=1.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 START MULTU 2x3, second START DIVU 9/3 at cycle 5 -> ignored, HI=0, LO=6; back-to-back START on DONE cycle -> accepted, next DONE 33 cycles later.
REQ-033 RST_N low for one edge at cycle 10 of an operation -> BUSY=0, HI=LO=0 next cycle, no DONE pulse within 40 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - WIDTH       : datapath width (fixed at 32 bits)
//   - ITERATIONS  : number of shift-add / restoring-divide iterations
//   - op_e        : operation encodings (MULT, MULTU, DIV, DIVU)
//   - state_e     : control FSM states (IDLE, CALC, FINISH)
//   - absVal()    : magnitude of an operand, honouring signedness
package mult_div_unit_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ITERATIONS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  // Two's-complement magnitude when the operation is signed and the value is
  // negative. 0x80000000 maps to itself, which is the correct unsigned
  // magnitude 2^31.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] value,
                                              input logic             isSigned);
    return (isSigned && value[WIDTH-1]) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative 32-bit multiply / divide unit with a fixed 33-cycle latency.
// Multiply and divide share a single 64-bit accumulator/shift register and
// operate on operand magnitudes. Signs are reapplied when the result is
// written to HI/LO.
//
// Ports:
//   clk_i          : clock, all state updates on the rising edge
//   rst_ni         : synchronous active-low reset
//   start_i        : request pulse, sampled only in IDLE
//   op_i[1:0]      : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a_i    : rs value (multiplicand / dividend)
//   operand_b_i    : rt value (multiplier / divisor)
//   busy_o         : high while the FSM is not in IDLE
//   done_o         : one-cycle pulse after HI/LO were updated
//   hi_o           : product high word / remainder
//   lo_o           : product low word / quotient
//   div_by_zero_o  : divide with zero divisor, held until the next done
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  state_e               state_q;
  op_e                  op_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     operand_q;
  logic [WIDTH-1:0]     aRaw_q;
  logic                 negLo_q;
  logic                 negHi_q;
  logic                 divZero_q;
  logic [5:0]           counter_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 isMult;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       partial;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;

  assign isMult = (op_q == OP_MULT) || (op_q == OP_MULTU);

  // One iteration of the shared datapath.
  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift right keeping the carry.
  // Divide: shift left, trial-subtract the divisor from the 33-bit partial
  // remainder; a clear bit 32 means no borrow, so keep it and set the
  // quotient bit.
  always_comb begin
    acc_d   = acc_q;
    sum     = '0;
    partial = '0;
    diff    = '0;
    if (isMult) begin
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end else begin
      partial = acc_q[2*WIDTH-1:WIDTH-1];
      diff    = partial - {1'b0, operand_q};
      if (!diff[WIDTH]) begin
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // Final sign correction and the divide-by-zero override applied in FINISH.
  always_comb begin
    product = negLo_q ? (~acc_q + 1'b1) : acc_q;
    hi_d    = '0;
    lo_d    = '0;
    if (isMult) begin
      hi_d = product[2*WIDTH-1:WIDTH];
      lo_d = product[WIDTH-1:0];
    end else if (divZero_q) begin
      hi_d = aRaw_q;
      lo_d = '1;
    end else begin
      hi_d = negHi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
      lo_d = negLo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
  end

  // Control FSM with registered outputs. Operands are latched on acceptance
  // so later changes on the inputs have no effect. For multiply the
  // accumulator starts with |B| in the low half and |A| is the addend; for
  // divide it starts with |A| (dividend) and |B| is the divisor.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      acc_q     <= '0;
      operand_q <= '0;
      aRaw_q    <= '0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      divZero_q <= 1'b0;
      counter_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            logic isSigned;
            logic mulReq;
            isSigned  = (op_i == OP_MULT) || (op_i == OP_DIV);
            mulReq    = (op_i == OP_MULT) || (op_i == OP_MULTU);
            op_q      <= op_e'(op_i);
            aRaw_q    <= operand_a_i;
            negLo_q   <= isSigned && (operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1]);
            negHi_q   <= isSigned && operand_a_i[WIDTH-1];
            divZero_q <= !mulReq && (operand_b_i == '0);
            if (mulReq) begin
              acc_q     <= {{WIDTH{1'b0}}, absVal(operand_b_i, isSigned)};
              operand_q <= absVal(operand_a_i, isSigned);
            end else begin
              acc_q     <= {{WIDTH{1'b0}}, absVal(operand_a_i, isSigned)};
              operand_q <= absVal(operand_b_i, isSigned);
            end
            counter_q <= '0;
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          if (counter_q == 6'(ITERATIONS - 1)) begin
            counter_q <= '0;
            state_q   <= ST_FINISH;
          end else begin
            counter_q <= counter_q + 6'd1;
          end
        end
        ST_FINISH: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dbz_q   <= divZero_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule
